// File: rtl/ct_spsram_access_ctrl.sv
// Request-side controller for a single-port SRAM: turns a valid/ready read/write stream into
// active-low CEN/GWEN/WEN pin drive, buffers read data in a 2-entry response FIFO, and zero-fills after reset.
module ct_spsram_access_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 128,
    parameter int INIT_EN    = 1
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   ram_a,
    output logic                    ram_cen,
    output logic                    ram_gwen,
    output logic [DATA_WIDTH-1:0]   ram_wen,
    output logic [DATA_WIDTH-1:0]   ram_d,
    input  logic [DATA_WIDTH-1:0]   ram_q,
    output logic [1:0]              o_dbg_state
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic [DATA_WIDTH-1:0] r_ram_d;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic                  w_run;
    logic                  w_init;
    logic                  w_credit_ok;
    logic                  w_acc;
    logic                  w_rd_acc;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_wen_wr;

    // State register.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = (INIT_EN != 0) ? ST_INIT : ST_RUN;
            ST_INIT: if (r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    generate
        for (genvar k = 0; k < BE_W; k++) begin : g_wen
            assign w_wen_wr[8*k +: 8] = {8{~req_be[k]}};
        end
    endgenerate

    // Handshake: a request transfers on a cycle where req_vld & req_rdy, a response on rsp_vld & rsp_rdy.
    // A read needs a free slot counting the one still in flight, so SRAM data is never dropped.
    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_init      = (r_state == ST_INIT);
        w_credit_ok = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2;
        req_rdy     = w_run & (req_wr | w_credit_ok);
        w_acc       = req_vld & req_rdy;
        w_rd_acc    = w_acc & ~req_wr;
        ram_cen     = 1'b1;
        ram_gwen    = 1'b1;
        ram_wen     = '1;
        ram_a       = r_ram_a;
        ram_d       = r_ram_d;
        if (w_init) begin
            ram_cen  = 1'b0;
            ram_gwen = 1'b0;
            ram_wen  = '0;
            ram_a    = r_cnt;
            ram_d    = '0;
        end else if (w_acc) begin
            ram_cen = 1'b0;
            ram_a   = req_addr;
            if (req_wr) begin
                ram_gwen = 1'b0;
                ram_wen  = w_wen_wr;
                ram_d    = req_wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_inflight  <= 1'b0;
            r_ram_a     <= '0;
            r_ram_d     <= '0;
        end else begin
            if (w_init) r_cnt <= r_cnt + 1'b1;
            r_init_done <= (w_state_nxt == ST_RUN);
            r_inflight  <= w_rd_acc;
            // Address/data pins hold between operations.
            r_ram_a     <= ram_a;
            r_ram_d     <= ram_d;
        end
    end

    assign w_push = r_inflight;
    assign w_pop  = rsp_vld & rsp_rdy;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= ram_q;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rsp_vld     = (r_count != 2'd0);
    assign rsp_rdata   = r_mem[r_rptr];
    assign init_done   = r_init_done;
    assign o_dbg_state = r_state;

    a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        !(w_push && (r_count == 2'd2) && !w_pop));

endmodule

// File: tb/tb_ct_spsram_access_ctrl.sv
// Bench for ct_spsram_access_ctrl with a behavioural SRAM, a scoreboard of expected read data,
// a vector table for pin-level checks and hand-written reset/backpressure sequences.
module tb_ct_spsram_access_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] ram_a;
    logic          ram_cen, ram_gwen;
    logic [DW-1:0] ram_wen, ram_d;
    logic [DW-1:0] ram_q = '0;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            acc_q[$];
    bit            exp_run = 1'b0;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;

    logic [DW-1:0] sram [DEPTH];
    bit            seeded = 1'b0;

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        logic          rr;
        logic          e_rdy;
        logic          e_cen;
        logic          e_gwen;
        logic [DW-1:0] e_wen;
        logic          e_rv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    ct_spsram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rst_n),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_be        (req_be),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_rdata     (rsp_rdata),
        .init_done     (init_done),
        .ram_a         (ram_a),
        .ram_cen       (ram_cen),
        .ram_gwen      (ram_gwen),
        .ram_wen       (ram_wen),
        .ram_d         (ram_d),
        .ram_q         (ram_q),
        .o_dbg_state   (dbg_state)
    );

    // Single-port SRAM: one-cycle read latency, bit-masked writes, starts with junk.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= $urandom;
            seeded <= 1'b1;
        end else if (!ram_cen) begin
            if (!ram_gwen) sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
            else           ram_q <= sram[ram_a];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] wen_of(input logic [BW-1:0] be);
        logic [DW-1:0] r;
        for (int k = 0; k < BW; k++) r[8*k +: 8] = be[k] ? 8'h00 : 8'hFF;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check mid-cycle, update the reference model.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] b, input logic rr,
                        output logic acc);
        logic          exp_rdy, exp_rv;
        logic [DW-1:0] mask;
        @(negedge clk);
        req_vld = v; req_wr = w; req_addr = a; req_wdata = d; req_be = b; rsp_rdy = rr;
        #2;
        exp_rdy = exp_run && (w || acc_q.size() < 2);
        chk("req_rdy", DW'(req_rdy), DW'(exp_rdy));
        exp_rv = exp_run && acc_q.size() > 0 && cyc >= acc_q[0] + 2;
        chk("rsp_vld", DW'(rsp_vld), DW'(exp_rv));
        if (exp_rv) begin
            chk("rsp_rdata", rsp_rdata, exp_q[0]);
            if (rr) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
        end
        acc = v && exp_rdy;
        if (exp_run) begin
            chk("init_done_high", DW'(init_done), DW'(1));
            if (acc) begin
                chk("acc_cen", DW'(ram_cen), DW'(0));
                chk("acc_a", DW'(ram_a), DW'(a));
                chk("acc_gwen", DW'(ram_gwen), DW'(!w));
                if (w) begin
                    chk("wr_wen", ram_wen, wen_of(b));
                    chk("wr_d", ram_d, d);
                    mask         = ~wen_of(b);
                    model_mem[a] = (model_mem[a] & ~mask) | (d & mask);
                    last_d       = d;
                end else begin
                    chk("rd_wen", ram_wen, '1);
                    exp_q.push_back(model_mem[a]);
                    acc_q.push_back(cyc);
                end
                last_a = a;
            end else begin
                chk("nop_cen", DW'(ram_cen), DW'(1));
                chk("nop_gwen", DW'(ram_gwen), DW'(1));
                chk("nop_wen", ram_wen, '1);
                chk("nop_a_hold", DW'(ram_a), DW'(last_a));
                chk("nop_d_hold", ram_d, last_d);
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr, acc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, DW'(req_rdy), DW'(0));
        chk({tag, "_rsp_vld"}, DW'(rsp_vld), DW'(0));
        chk({tag, "_rsp_rdata"}, rsp_rdata, '0);
        chk({tag, "_init_done"}, DW'(init_done), DW'(0));
        chk({tag, "_cen"}, DW'(ram_cen), DW'(1));
        chk({tag, "_gwen"}, DW'(ram_gwen), DW'(1));
        chk({tag, "_wen"}, ram_wen, '1);
        chk({tag, "_a"}, DW'(ram_a), DW'(0));
        chk({tag, "_d"}, ram_d, '0);
        chk({tag, "_state"}, DW'(dbg_state), DW'(0));
    endtask

    task automatic assert_reset(input string tag);
        rst_n   = 1'b0;
        req_vld = 1'b0;
        rsp_rdy = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        acc_q.delete();
        exp_run = 1'b0;
    endtask

    // Release reset and walk the fill; stop_at >= 0 returns mid-fill with ram_a == stop_at.
    task automatic run_init(input int stop_at);
        logic acc;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("idle_init_done", DW'(init_done), DW'(0));
        chk("idle_cen", DW'(ram_cen), DW'(1));
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, 1'b0, '0, '0, '0, 1'b1, acc);
            chk("init_a", DW'(ram_a), DW'(k));
            chk("init_cen", DW'(ram_cen), DW'(0));
            chk("init_gwen", DW'(ram_gwen), DW'(0));
            chk("init_wen", ram_wen, '0);
            chk("init_d", ram_d, '0);
            chk("init_done_low", DW'(init_done), DW'(0));
            if (k == stop_at) return;
        end
        exp_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        last_a = AW'(DEPTH - 1);
        last_d = '0;
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
        chk("init_done_rise", DW'(init_done), DW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [AW-1:0] ad [4];
        int            n;

        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_rdy = 1'b0;
        #1;
        assert_reset("por");
        repeat (2) @(posedge clk);

        // Fill, then every word reads back as zero.
        run_init(-1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b1, acc);
        idle(4, 1'b1);

        // Pin-level vectors: write/read-after-write, partial and empty byte masks.
        tbl[0] = '{1'b1, 1'b1, 4'd3, 32'h01234567, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 4'd3, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h01234567};
        tbl[4] = '{1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 4'd5, 32'h00000000, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 4'd5, 32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 4'd5, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFF00};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].rr, acc);
            chk($sformatf("vec%0d_rdy", i), DW'(req_rdy), DW'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_cen", i), DW'(ram_cen), DW'(tbl[i].e_cen));
            chk($sformatf("vec%0d_gwen", i), DW'(ram_gwen), DW'(tbl[i].e_gwen));
            chk($sformatf("vec%0d_wen", i), ram_wen, tbl[i].e_wen);
            chk($sformatf("vec%0d_rsp_vld", i), DW'(rsp_vld), DW'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("vec%0d_rdata", i), rsp_rdata, tbl[i].e_rdata);
        end
        idle(3, 1'b1);

        // Credit stall: only two reads go out while responses are held back.
        ad[0] = 4'd1; ad[1] = 4'd3; ad[2] = 4'd5; ad[3] = 4'd7;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, ad[i], $urandom, 4'hF, 1'b1, acc);
        n = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, ad[n], '0, '0, 1'b0, acc);
            if (acc) n++;
        end
        chk("stall_accepts", DW'(n), DW'(2));
        chk("stall_rdy_low", DW'(req_rdy), DW'(0));
        for (int c = 0; c < 20 && n < 4; c++) begin
            step(1'b1, 1'b0, ad[n], '0, '0, 1'b1, acc);
            if (acc) n++;
        end
        chk("stall_resume", DW'(n), DW'(4));
        idle(5, 1'b1);
        chk("stall_drained", DW'(exp_q.size()), DW'(0));

        // Full buffer still takes writes.
        step(1'b1, 1'b0, 4'd2, '0, '0, 1'b0, acc);
        step(1'b1, 1'b0, 4'd4, '0, '0, 1'b0, acc);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 4'd9, 32'hA5A5_5A5A, 4'hF, 1'b0, acc);
        chk("full_wr_acc", DW'(acc), DW'(1));
        chk("full_wr_cen", DW'(ram_cen), DW'(0));
        chk("full_wr_gwen", DW'(ram_gwen), DW'(0));
        idle(4, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                 $urandom, BW'($urandom_range(0, (1 << BW) - 1)), ($urandom_range(0, 3) != 0), acc);
        end
        idle(6, 1'b1);
        chk("random_drained", DW'(exp_q.size()), DW'(0));

        // Reset while one response is buffered.
        step(1'b1, 1'b0, 4'd9, '0, '0, 1'b0, acc);
        idle(2, 1'b0);
        chk("pre_reset_rsp_vld", DW'(rsp_vld), DW'(1));
        assert_reset("rst_rsp");

        // Reset mid-fill at address 7, then the full fill restarts from 0.
        run_init(7);
        assert_reset("rst_init");
        run_init(-1);
        step(1'b1, 1'b0, 4'd9, '0, '0, 1'b1, acc);
        step(1'b1, 1'b0, 4'd5, '0, '0, 1'b1, acc);
        idle(4, 1'b1);
        chk("final_drained", DW'(exp_q.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ct_spsram_access_ctrl.md
Name: ct_spsram_access_ctrl

Overview:
- Request-side controller that sits directly upstream of the single-port FPGA SRAM wrapper (32768x128 class).
- Converts a valid/ready request stream (read, or byte-masked write) into the SRAM's active-low CEN/GWEN/bit-WEN pin protocol.
- Captures read data after the SRAM's one-cycle latency into a 2-entry response buffer with valid/ready backpressure.
- Optionally zero-fills the whole array after reset before accepting traffic.

Parameters:
ADDR_WIDTH, 15, SRAM word-address width.
DATA_WIDTH, 128, SRAM data width; must be a multiple of 8.
INIT_EN, 1, 1 = zero-fill all 2^ADDR_WIDTH words after reset; 0 = skip the fill.

Ports:
forever_cpuclk  input  1  clock; also drives the SRAM CLK.
cpurst_b  input  1  asynchronous active-low reset.
req_vld  input  1  request valid.
req_rdy  output  1  request ready.
req_wr  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  write data.
req_be  input  DATA_WIDTH/8  byte enables, active-high.
rsp_vld  output  1  read response valid.
rsp_rdy  input  1  read response ready.
rsp_rdata  output  DATA_WIDTH  read data.
init_done  output  1  high once the array is usable.
ram_a  output  ADDR_WIDTH  to SRAM A.
ram_cen  output  1  to SRAM CEN, active-low.
ram_gwen  output  1  to SRAM GWEN, active-low.
ram_wen  output  DATA_WIDTH  to SRAM WEN, active-low per bit.
ram_d  output  DATA_WIDTH  to SRAM D.
ram_q  input  DATA_WIDTH  from SRAM Q.

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset cpurst_b is asynchronous and active-low.
- Reset values:
  - state = IDLE, init counter = 0, response buffer empty, in-flight flag = 0.
  - Outputs: req_rdy=0, rsp_vld=0, rsp_rdata=0, init_done=0, ram_cen=1, ram_gwen=1, ram_wen=all 1, ram_a=0, ram_d=0.
- FSM states: IDLE, INIT, RUN.
  - IDLE -> INIT on the first clock after reset if INIT_EN=1, else IDLE -> RUN.
  - INIT -> RUN on the cycle the counter reaches 2^ADDR_WIDTH-1.
  - RUN is terminal until reset.
  - Reset asserted in any state returns to IDLE. An interrupted fill restarts from address 0.
- INIT behaviour:
  - Each cycle drives ram_cen=0, ram_gwen=0, ram_wen=all 0, ram_d=0, ram_a=counter; counter increments by 1.
  - Fill takes exactly 2^ADDR_WIDTH cycles.
  - req_rdy=0 throughout.
- init_done is registered: rises on the first RUN cycle and stays high.
- RAM pin drive in RUN is combinational from the accepted request; at most one SRAM op per cycle.
  - When req_vld & req_rdy: ram_cen=0, ram_a=req_addr.
  - Write: ram_gwen=0, ram_d=req_wdata, ram_wen[8k+j] = !req_be[k].
  - Write with req_be all zero: still issued, ram_gwen=0 but ram_wen all 1, so no bits change.
  - Read: ram_gwen=1, ram_wen=all 1.
  - No handshake: ram_cen=1, ram_gwen=1, ram_wen=all 1. ram_a and ram_d hold their last values (SRAM holds its own address).
- Read latency:
  - Read accepted at edge t.
  - ram_q is valid during cycle t+1 and is pushed into the response buffer at edge t+1; the in-flight flag is set for cycle t+1.
  - rsp_vld is high from cycle t+1 after edge t+1, i.e. earliest 2 cycles after request acceptance.
- Response buffer:
  - 2-entry FIFO, in-order; rsp_rdata = head entry.
  - Pop on rsp_vld & rsp_rdy. Push and pop in the same cycle are allowed and the count is unchanged.
- Credit rule: req_rdy = RUN & (req_wr | (fifo_count + inflight) < 2).
  - Writes never stall and never produce a response.
  - A read is never accepted without a guaranteed buffer slot, so ram_q is never dropped.
- Write-then-read to the same address on consecutive cycles returns the new data, since the SRAM is write-first across cycles.

Test Plan:
1. ADDR_WIDTH=4, INIT_EN=1, release reset -> init_done rises after 1 IDLE cycle + 16 INIT cycles. Reads of addr 0..15 all return 0.
2. Write addr 3 data 0x0123..EF with all bytes enabled, then read addr 3 on the next cycle -> rsp_vld 2 cycles after the read is accepted, rsp_rdata = written data.
3. Write 0xFF.. to addr 5, then write 0x00.. with req_be=0x0001 -> ram_wen low only on bits 7:0. Read of addr 5 returns 0xFF..FF00.
4. Hold rsp_rdy=0 and issue 4 back-to-back reads -> 2 accepted, req_rdy drops to 0 with fifo_count+inflight=2. Release rsp_rdy -> the remaining reads issue, and all 4 responses arrive in order with correct data.
5. With rsp_rdy=0 and the buffer full, issue a write -> accepted immediately. ram_cen=0, ram_gwen=0 for that cycle.
6. Assert cpurst_b=0 mid-INIT at counter 7 and mid-response with the buffer holding 1 entry -> all outputs return to reset values asynchronously. The fill restarts at address 0 and takes the full 16 cycles.
